// File: rtl/uart_pkg.sv
// Shared types and constants for the UART line receiver.
// No logic; state encoding, oversampling constants and divider helper only.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  localparam int OversampleRate = 16;
  localparam int SampleTick     = 7;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OversampleRate);
  endfunction

endpackage

// File: rtl/uart_line_rx_fifo.sv
// Generic synchronous FIFO, registered storage, head presented combinationally.
// Latency: write visible at the head one cycle after the push.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module uart_line_rx_fifo #(
  parameter int Width = 9,
  parameter int Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [Width-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [Width-1:0] out_dat
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             full, wr_en, rd_en;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign out_vld = (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign rd_en   = out_vld && out_rdy;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign in_rdy  = !full || out_rdy;
  assign wr_en   = in_vld && in_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_dat;
  end

endmodule

// File: rtl/uart_line_rx.sv
// 16x-oversampled UART receiver that tags line ends and queues {last,data}; UART_LINE_RX_GLITCH_FILTER_EN enables 2-of-3 sampling.
// Latency: byte reaches the FIFO head two cycles after the stop-bit sample.
// Backpressure: none on the line; a byte arriving at a full, unpopped FIFO is dropped and flagged.
module uart_line_rx
  import uart_pkg::*;
#(
  parameter int         ClkFrequency = 20_000_000,
  parameter int         BaudRate     = 115200,
  parameter int         DataBits     = 8,
  parameter int         ParityEn     = 0,
  parameter int         ParityOdd    = 0,
  parameter logic [7:0] LineEndChar  = 8'h0A,
  parameter int         MaxLineLen   = 80,
  parameter int         FifoDepth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  input  logic                clr_i,
  output logic [DataBits-1:0] data_o,
  output logic                last_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int Div   = calc_div(ClkFrequency, BaudRate);
  localparam int DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int LineW = (MaxLineLen > 1) ? $clog2(MaxLineLen) : 1;
  localparam int BitW  = 3;
`ifdef UART_LINE_RX_GLITCH_FILTER_EN
  localparam int DecideTick = SampleTick + 1;
`else
  localparam int DecideTick = SampleTick;
`endif

  if (Div < 1 || DataBits < 5 || DataBits > 8 || MaxLineLen < 1) begin : g_param_chk
    $fatal(1, "uart_line_rx: invalid parameters (Div=%0d DataBits=%0d)", Div, DataBits);
  end

  uart_rx_state_e      state_q, state_d;
  logic                rx_meta, rx_s, rx_q;
  logic [DivW-1:0]     div_cnt_q;
  logic [3:0]          tick_cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [DataBits-1:0] shift_q;
  logic [LineW-1:0]    line_cnt_q;
  logic                parity_bad_q, push_q;
  logic                busy, tick, samp_stb, samp_bit, line_last;
  logic                shift_en, par_chk, push_d, frame_err_d, parity_err_d;
  logic                fifo_in_rdy, fifo_out_vld;
  logic [DataBits:0]   fifo_out_dat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign busy   = (state_q != IDLE);
  assign busy_o = busy;
  assign tick   = busy && (div_cnt_q == DivW'(Div - 1));

  // Baud timing only runs inside a frame so every frame starts phase-aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else if (!busy) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= tick_cnt_q + 4'd1;
    end else begin
      div_cnt_q  <= div_cnt_q + DivW'(1);
    end
  end

`ifdef UART_LINE_RX_GLITCH_FILTER_EN
  logic [1:0] early_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      early_q <= 2'b11;
    end else if (!busy) begin
      early_q <= 2'b11;
    end else if (tick && tick_cnt_q == 4'(SampleTick - 1)) begin
      early_q[0] <= rx_s;
    end else if (tick && tick_cnt_q == 4'(SampleTick)) begin
      early_q[1] <= rx_s;
    end
  end

  assign samp_bit = (early_q[0] & early_q[1]) | (early_q[0] & rx_s) | (early_q[1] & rx_s);
`else
  assign samp_bit = rx_s;
`endif
  assign samp_stb = tick && (tick_cnt_q == 4'(DecideTick));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    shift_en     = 1'b0;
    par_chk      = 1'b0;
    push_d       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      IDLE:   if (rx_q && !rx_s) state_d = START;
      START:  if (samp_stb) state_d = samp_bit ? IDLE : DATA;
      DATA: begin
        if (samp_stb) begin
          shift_en = 1'b1;
          if (bit_cnt_q == BitW'(DataBits - 1)) state_d = (ParityEn != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (samp_stb) begin
          par_chk = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (samp_stb) begin
          if (!samp_bit) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            parity_err_d = parity_bad_q;
            push_d       = !parity_bad_q;
            state_d      = IDLE;
          end
        end
      end
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_bad_q <= 1'b0;
      push_q       <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (state_q == START) begin
        bit_cnt_q    <= '0;
        parity_bad_q <= 1'b0;
      end
      if (shift_en) begin
        shift_q   <= {samp_bit, shift_q[DataBits-1:1]};
        bit_cnt_q <= bit_cnt_q + BitW'(1);
      end
      if (par_chk) parity_bad_q <= samp_bit ^ (^shift_q) ^ 1'(ParityOdd);
      push_q       <= push_d;
      frame_err_o  <= frame_err_d;
      parity_err_o <= parity_err_d;
    end
  end

  assign line_last = (shift_q == LineEndChar[DataBits-1:0]) ||
                     (line_cnt_q == LineW'(MaxLineLen - 1));

  // Only accepted bytes count towards the line; a clear overrides the advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_cnt_q <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (clr_i)                       line_cnt_q <= '0;
      else if (push_q && fifo_in_rdy)  line_cnt_q <= line_last ? '0 : line_cnt_q + LineW'(1);
      if (push_q && !fifo_in_rdy)      overflow_o <= 1'b1;
      else if (clr_i)                  overflow_o <= 1'b0;
    end
  end

  uart_line_rx_fifo #(
    .Width (DataBits + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_vld  (push_q),
    .in_rdy  (fifo_in_rdy),
    .in_dat  ({line_last, shift_q}),
    .out_vld (fifo_out_vld),
    .out_rdy (ready_i),
    .out_dat (fifo_out_dat)
  );

  assign valid_o = fifo_out_vld;
  assign data_o  = fifo_out_vld ? fifo_out_dat[DataBits-1:0] : '0;
  assign last_o  = fifo_out_vld && fifo_out_dat[DataBits];

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: 20 MHz / 115200 baud (160 clk per bit), even parity, 8-byte lines, 4-deep FIFO.
module tb_uart_line_rx;

  localparam int BitClks = 160;
  localparam int MaxLine = 8;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       rx_i    = 1'b1;
  logic       clr_i   = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       last_o, valid_o, frame_err_o, parity_err_o, overflow_o, busy_o;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_last = 0;
  int         lc     = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;

  uart_line_rx #(
    .ClkFrequency (20_000_000),
    .BaudRate     (115200),
    .DataBits     (8),
    .ParityEn     (1),
    .ParityOdd    (0),
    .LineEndChar  (8'h0A),
    .MaxLineLen   (MaxLine),
    .FifoDepth    (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .clr_i        (clr_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
  );

  always #25 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line model: a byte closes the line on the end char or when it is the MaxLine-th byte.
  task automatic exp_push(input logic [7:0] b);
    logic l;
    l = (b == 8'h0A) || (lc == MaxLine - 1);
    exp_q.push_back({l, b});
    lc = l ? 0 : lc + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rx_i = v;
    cycles(BitClks);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_flip, input logic stop_v);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out((^b) ^ par_flip);
    bit_out(stop_v);
    rx_i = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk_i);
    #1;
    check(tag, 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk_i) begin
    if (frame_err_o)  n_ferr++;
    if (parity_err_o) n_perr++;
    if (rst_ni && valid_o && ready_i) begin
      if (last_o) n_last++;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(exp_q.size()), 1);
      end else begin
        exp_e = exp_q.pop_front();
        check("pop_data", 32'(data_o), 32'(exp_e[7:0]));
        check("pop_last", 32'(last_o), 32'(exp_e[8]));
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, pe0, l0;

    cycles(3);
    check("rst_valid",   32'(valid_o), 0);
    check("rst_busy",    32'(busy_o), 0);
    check("rst_ovf",     32'(overflow_o), 0);
    check("rst_ferr",    32'(frame_err_o), 0);
    check("rst_perr",    32'(parity_err_o), 0);
    check("rst_data",    32'(data_o), 0);
    check("rst_last",    32'(last_o), 0);
    rst_ni = 1'b1;
    cycles(5);
    ready_i = 1'b1;

    // "Hi\n": the newline closes the line
    fe0 = n_ferr; pe0 = n_perr;
    exp_push(8'h48); send_byte(8'h48, 1'b0, 1'b1);
    exp_push(8'h69); send_byte(8'h69, 1'b0, 1'b1);
    exp_push(8'h0A); send_byte(8'h0A, 1'b0, 1'b1);
    cycles(20);
    drain("hi_drain");
    check("hi_ferr", 32'(n_ferr - fe0), 0);
    check("hi_perr", 32'(n_perr - pe0), 0);

    // MaxLine+1 bytes with no end char: only the MaxLine-th is last
    l0 = n_last;
    for (int i = 0; i < MaxLine + 1; i++) begin
      exp_push(8'h61);
      send_byte(8'h61, 1'b0, 1'b1);
    end
    cycles(20);
    drain("maxlen_drain");
    check("maxlen_lasts", 32'(n_last - l0), 1);

    // Bad parity: one pulse, nothing queued
    fe0 = n_ferr; pe0 = n_perr;
    send_byte(8'h07, 1'b1, 1'b1);
    cycles(20);
    check("par_pulses",  32'(n_perr - pe0), 1);
    check("par_no_ferr", 32'(n_ferr - fe0), 0);
    check("par_empty",   32'(valid_o), 0);

    // Stop bit low, line held low for three bit times in total
    fe0 = n_ferr; pe0 = n_perr;
    send_byte(8'h55, 1'b0, 1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    check("brk_busy", 32'(busy_o), 1);
    rx_i = 1'b1;
    cycles(10);
    check("brk_idle",    32'(busy_o), 0);
    check("frm_pulses",  32'(n_ferr - fe0), 1);
    check("frm_no_perr", 32'(n_perr - pe0), 0);
    check("frm_empty",   32'(valid_o), 0);

    // Overflow: six bytes into a 4-deep FIFO with no consumer
    ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_push(8'(i));
      send_byte(8'(i), 1'b0, 1'b1);
    end
    cycles(20);
    check("ovf_set",   32'(overflow_o), 1);
    check("ovf_valid", 32'(valid_o), 1);
    check("ovf_head",  32'(data_o), 32'h01);
    ready_i = 1'b1;
    drain("ovf_drain");
    clr_i = 1'b1;
    cycles(1);
    clr_i = 1'b0;
    lc = 0;
    cycles(1);
    check("ovf_clr", 32'(overflow_o), 0);

    // Short low glitches on an idle line
    fe0 = n_ferr; pe0 = n_perr;
    rx_i = 1'b0; cycles(3); rx_i = 1'b1;
    cycles(250);
    check("gl3_busy",  32'(busy_o), 0);
    check("gl3_empty", 32'(valid_o), 0);
    rx_i = 1'b0; cycles(15); rx_i = 1'b1;
    cycles(250);
    check("gl15_busy",  32'(busy_o), 0);
    check("gl15_empty", 32'(valid_o), 0);
    check("gl_ferr",    32'(n_ferr - fe0), 0);
    check("gl_perr",    32'(n_perr - pe0), 0);

    // Reset in the middle of a frame flushes everything
    ready_i = 1'b0;
    send_byte(8'h33, 1'b0, 1'b1);
    cycles(20);
    check("pre_rst_valid", 32'(valid_o), 1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    check("mid_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 0);
    check("arst_busy",  32'(busy_o), 0);
    check("arst_data",  32'(data_o), 0);
    check("arst_last",  32'(last_o), 0);
    rx_i = 1'b1;
    lc = 0;
    cycles(5);
    rst_ni = 1'b1;
    cycles(5);
    ready_i = 1'b1;
    exp_push(8'hA5);
    send_byte(8'hA5, 1'b0, 1'b1);
    cycles(20);
    drain("a5_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
